stim_gen: RTL and testbench
===========================

STIM_GEN -- requirements
Module: stim_gen

Interface
REQ-001 Parameter WIDTH, default 32, logic [7:0]: pattern word width in bits, 1..32.
REQ-002 Parameter DEPTH, default 1024, int: pattern RAM depth in words, a power of two.
REQ-003 clk  input  1: sole clock; all logic on its rising edge.
REQ-004 rst  input  1: synchronous, active-high reset.
REQ-005 trigger_in  input  1: external start strobe; sampled only in ARMED.
REQ-006 pattern_out  output  WIDTH: played-back word; zero when pattern_valid is low.
REQ-007 pattern_valid  output  1: high on each cycle pattern_out carries a pattern word.
REQ-008 busy  output  1: high in ARMED, PRIME or PLAY.
REQ-009 bus_addr  input  32: bus address.
REQ-010 bus_wen  input  1: bus write strobe, one cycle per write.
REQ-011 bus_ren  input  1: bus read strobe; informational only, reads are side-effect free.
REQ-012 bus_wdata  input  32: bus write data.
REQ-013 bus_rdata  output  32: combinational read mux.

Function
REQ-014 Registers SHALL use reg_map_pkg constants R_STIM_INFO, R_STIM_CTRL, R_STIM_STATUS, R_STIM_LEN and R_STIM_LOOPS; every other address SHALL access pattern RAM at bus_addr[$clog2(DEPTH)-1:0].
REQ-015 The pattern RAM SHALL be a single-port synchronous RAM with one-cycle read latency; bus RAM read data SHALL be valid one cycle after the address is presented.
REQ-016 A bus RAM write SHALL take effect only in IDLE or DONE; writes in other states SHALL be dropped.
REQ-017 The R_STIM_INFO read SHALL return {DEPTH[15:0], 8'h00, WIDTH}.
REQ-018 R_STIM_LEN SHALL be $clog2(DEPTH)+1 bits, reset 0, writable only in IDLE/DONE; written values above DEPTH SHALL clamp to DEPTH.
REQ-019 An R_STIM_CTRL write SHALL act as a strobe: bit0 ARM, bit1 ABORT, bit2 SWTRIG; it SHALL read back as 0.
REQ-020 The R_STIM_STATUS read SHALL return {29'b0, done, playing, armed}.
REQ-021 The FSM states SHALL be IDLE, ARMED, PRIME, PLAY and DONE.
REQ-022 FSM transitions:
- IDLE or DONE + ARM with LEN != 0 -> ARMED, clearing done.
- ARM with LEN == 0 SHALL be ignored.
REQ-023 ARMED + (trigger_in or SWTRIG) in cycle T -> PRIME at T+1 (RAM address 0 issued) -> PLAY at T+2.
REQ-024 Word k SHALL appear on pattern_out with pattern_valid high at cycle T+2+k, contiguous with no gaps, for k = 0..LEN-1.
REQ-025 After the last word of the last pass, the FSM SHALL go to DONE: pattern_valid SHALL be low and pattern_out SHALL be 0 the following cycle, and done SHALL be set sticky.
REQ-026 Triggers in IDLE, PRIME, PLAY or DONE SHALL be ignored; there SHALL be no retrigger.
REQ-027 ABORT in any state -> IDLE next cycle; pattern_valid SHALL drop that cycle, and done SHALL not be set.
REQ-028 When ARM and ABORT are written together, ABORT SHALL win.
REQ-029 LEN == DEPTH SHALL play every word; the play index SHALL wrap DEPTH-1 -> 0 without error.

Reset
REQ-030 rst SHALL force IDLE, pattern_out=0, pattern_valid=0, busy=0, done=0, LEN=0, LOOPS=0, and the play index to 0.
REQ-031 rst asserted mid-PLAY SHALL force the outputs low on the next cycle; RAM contents SHALL be retained.

Configuration
REQ-032 Macro STIM_GEN_LOOP_EN defined: R_STIM_LOOPS (16 bits, reset 0, writable in IDLE/DONE) SHALL give LOOPS+1 back-to-back passes, with index LEN-1 -> 0 seamless and no valid gap.
REQ-033 Macro STIM_GEN_LOOP_EN undefined: R_STIM_LOOPS SHALL read 0, writes SHALL be ignored, and there SHALL be a single pass.

Verification
REQ-034 Basic playback: write RAM[0..3]=0x11,0x22,0x33,0x44, LEN=4, ARM, trigger_in at T -> pattern_out 0x11..0x44 at T+2..T+5 with valid high, DONE at T+6, STATUS=0x4.
REQ-035 Ignored triggers: trigger_in pulses in IDLE and again during PLAY -> no effect; exactly 4 valid cycles.
REQ-036 Abort: ABORT at the second PLAY cycle -> valid low on the next cycle, STATUS=0, busy=0.
REQ-037 Zero length and full depth: LEN=0 then ARM -> stays IDLE; LEN=DEPTH+5 -> reads back DEPTH and plays DEPTH words, last word RAM[DEPTH-1].
REQ-038 Reset mid-play: rst during PLAY -> all outputs 0 next cycle; re-ARM with LEN rewritten to 4 -> RAM data intact.
REQ-039 Loop feature: with STIM_GEN_LOOP_EN, LOOPS=2, LEN=3 -> 9 contiguous valid words A,B,C,A,B,C,A,B,C; without it, 3 words.

Source files
------------

// File: rtl/stim_gen.sv
// ---------------------------------------------------------------------------
// reg_map_pkg : bus register addresses shared by the stimulus generator and
//               its software/bench counterparts.
//
// stim_gen    : pattern RAM playback engine.
//   Software loads a pattern into the RAM over a simple bus, programs a
//   length (and optionally a loop count), arms the engine, and a trigger
//   (trigger_in pin or a software strobe) starts contiguous playback of
//   the pattern on pattern_out / pattern_valid.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   trigger_in        external start strobe, sampled only while armed
//   pattern_out       played-back word, zero when pattern_valid is low
//   pattern_valid     high on every cycle pattern_out carries a word
//   busy              high while armed, priming or playing
//   bus_addr/wen/ren  register / RAM bus (ren is informational only)
//   bus_wdata         bus write data
//   bus_rdata         combinational read mux (RAM data one cycle late)
//
// Optional feature:
//   STIM_GEN_LOOP_EN  enables the R_STIM_LOOPS register (LOOPS+1 passes).
//                     Undefined: LOOPS reads 0, writes ignored, one pass.
// ---------------------------------------------------------------------------
package reg_map_pkg;
    localparam logic [31:0] R_STIM_INFO   = 32'h0001_0000;
    localparam logic [31:0] R_STIM_CTRL   = 32'h0001_0004;
    localparam logic [31:0] R_STIM_STATUS = 32'h0001_0008;
    localparam logic [31:0] R_STIM_LEN    = 32'h0001_000C;
    localparam logic [31:0] R_STIM_LOOPS  = 32'h0001_0010;
endpackage

module stim_gen
    import reg_map_pkg::*;
#(
    parameter logic [7:0] WIDTH = 8'd32,
    parameter int         DEPTH = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trigger_in,
    output logic [WIDTH-1:0] pattern_out,
    output logic             pattern_valid,
    output logic             busy,
    input  logic [31:0]      bus_addr,
    input  logic             bus_wen,
    input  logic             bus_ren,
    input  logic [31:0]      bus_wdata,
    output logic [31:0]      bus_rdata
);

    localparam int AW    = $clog2(DEPTH);
    localparam int LEN_W = AW + 1;
    localparam logic [15:0] DEPTH16 = 16'(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        PRIME,
        PLAY,
        DONE
    } state_t;

    state_t state, next_state;

    // Bus decode
    logic is_info, is_ctrl, is_status, is_len, is_loops, is_reg;
    logic arm, abort, swtrig, cfg_open;

    // Configuration and status
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] len_m1;
    logic [15:0]      loops_q;
    logic             done_q;
    logic             done_set, done_clr;
    logic             playing, armed;

    // Playback sequencing
    logic [AW-1:0]    issue_idx;
    logic [LEN_W-1:0] out_cnt;
    logic [15:0]      pass_cnt;
    logic             issue_wrap, out_last, pass_last;

    // Pattern RAM
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] ram_q;
    logic [AW-1:0]    ram_addr;
    logic             ram_we;

    // Reads have no side effects, so the read strobe carries no logic.
    logic unused_ren;
    assign unused_ren = bus_ren;

    // ------------------------------------------------------------------
    // Address decode and control strobes
    // ------------------------------------------------------------------
    always_comb begin
        is_info   = (bus_addr == R_STIM_INFO);
        is_ctrl   = (bus_addr == R_STIM_CTRL);
        is_status = (bus_addr == R_STIM_STATUS);
        is_len    = (bus_addr == R_STIM_LEN);
        is_loops  = (bus_addr == R_STIM_LOOPS);
        is_reg    = is_info | is_ctrl | is_status | is_len | is_loops;
        arm       = bus_wen & is_ctrl & bus_wdata[0];
        abort     = bus_wen & is_ctrl & bus_wdata[1];
        swtrig    = bus_wen & is_ctrl & bus_wdata[2];
        cfg_open  = (state == IDLE) || (state == DONE);
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state    = state;
        done_set      = 1'b0;
        done_clr      = 1'b0;
        busy          = (state == ARMED) || (state == PRIME) || (state == PLAY);
        playing       = (state == PRIME) || (state == PLAY);
        armed         = (state == ARMED);
        pattern_valid = (state == PLAY);

        // ABORT overrides every other transition, including a coincident ARM
        // and the final word of the last pass (done stays clear).
        if (abort) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (arm && (len_q != '0)) begin
                        next_state = ARMED;
                        done_clr   = 1'b1;
                    end
                end
                ARMED: begin
                    if (trigger_in || swtrig) begin
                        next_state = PRIME;
                    end
                end
                PRIME: begin
                    next_state = PLAY;
                end
                PLAY: begin
                    if (out_last && pass_last) begin
                        next_state = DONE;
                        done_set   = 1'b1;
                    end
                end
                default: begin
                    next_state = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            done_q <= 1'b0;
        end else if (done_set) begin
            done_q <= 1'b1;
        end else if (done_clr) begin
            done_q <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Configuration registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            len_q <= '0;
        end else if (bus_wen && is_len && cfg_open) begin
            if (bus_wdata > 32'(DEPTH)) begin
                len_q <= LEN_W'(DEPTH);
            end else begin
                len_q <= bus_wdata[LEN_W-1:0];
            end
        end
    end

`ifdef STIM_GEN_LOOP_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            loops_q <= '0;
        end else if (bus_wen && is_loops && cfg_open) begin
            loops_q <= bus_wdata[15:0];
        end
    end
`else
    assign loops_q = '0;
`endif

    // ------------------------------------------------------------------
    // Playback sequencing
    // The RAM address runs one word ahead of pattern_out. It wraps from
    // LEN-1 to 0 at the issue side, so a following pass starts without a
    // gap; out_cnt/pass_cnt track what is actually on the output.
    // ------------------------------------------------------------------
    always_comb begin
        len_m1     = len_q - LEN_W'(1);
        issue_wrap = ({1'b0, issue_idx} == len_m1);
        out_last   = (out_cnt == len_m1);
        pass_last  = (pass_cnt == loops_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            issue_idx <= '0;
            out_cnt   <= '0;
            pass_cnt  <= '0;
        end else begin
            if (playing) begin
                issue_idx <= issue_wrap ? '0 : issue_idx + AW'(1);
            end else begin
                issue_idx <= '0;
            end

            if (state == PLAY) begin
                if (out_last) begin
                    out_cnt  <= '0;
                    pass_cnt <= pass_cnt + 16'(1);
                end else begin
                    out_cnt  <= out_cnt + LEN_W'(1);
                end
            end else begin
                out_cnt  <= '0;
                pass_cnt <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Single-port pattern RAM, one-cycle read latency. Contents are not
    // touched by reset.
    // ------------------------------------------------------------------
    always_comb begin
        ram_we   = bus_wen && !is_reg && cfg_open;
        ram_addr = playing ? issue_idx : bus_addr[AW-1:0];
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr] <= bus_wdata[WIDTH-1:0];
        end
        ram_q <= mem[ram_addr];
    end

    assign pattern_out = pattern_valid ? ram_q : '0;

    // ------------------------------------------------------------------
    // Bus read mux
    // ------------------------------------------------------------------
    always_comb begin
        bus_rdata = 32'(ram_q);
        if (is_info) begin
            bus_rdata = {DEPTH16, 8'h00, WIDTH};
        end else if (is_ctrl) begin
            bus_rdata = '0;
        end else if (is_status) begin
            bus_rdata = {29'b0, done_q, playing, armed};
        end else if (is_len) begin
            bus_rdata = 32'(len_q);
        end else if (is_loops) begin
            bus_rdata = 32'(loops_q);
        end
    end

endmodule

// File: tb/tb_stim_gen.sv
// ---------------------------------------------------------------------------
// Self-checking bench for stim_gen (WIDTH=12, DEPTH=16).
// Register/RAM access vectors are table driven; playback scenarios are
// hand-written sequences with expected words kept in exp_seq.
// ---------------------------------------------------------------------------
module tb_stim_gen;
    import reg_map_pkg::*;

    localparam logic [7:0] W = 8'd12;
    localparam int         D = 16;

`ifdef STIM_GEN_LOOP_EN
    localparam bit LOOP_EN = 1'b1;
`else
    localparam bit LOOP_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          trigger_in;
    logic [W-1:0]  pattern_out;
    logic          pattern_valid;
    logic          busy;
    logic [31:0]   bus_addr;
    logic          bus_wen;
    logic          bus_ren;
    logic [31:0]   bus_wdata;
    logic [31:0]   bus_rdata;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_seq[$];
    logic [11:0] exp_mem[D];

    typedef struct {
        string       name;
        bit          wr;
        bit          ram;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    stim_gen #(.WIDTH(W), .DEPTH(D)) dut (
        .clk           (clk),
        .rst           (rst),
        .trigger_in    (trigger_in),
        .pattern_out   (pattern_out),
        .pattern_valid (pattern_valid),
        .busy          (busy),
        .bus_addr      (bus_addr),
        .bus_wen       (bus_wen),
        .bus_ren       (bus_ren),
        .bus_wdata     (bus_wdata),
        .bus_rdata     (bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic add_vec(input string name, input bit wr, input bit ram,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] exp);
        vec_t v;
        v.name = name; v.wr = wr; v.ram = ram;
        v.addr = addr; v.wdata = wdata; v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        bus_addr  = addr;
        bus_wdata = data;
        bus_wen   = 1'b1;
        step();
        bus_wen   = 1'b0;
    endtask

    task automatic read_reg(input logic [31:0] addr, output logic [31:0] data);
        bus_addr = addr;
        bus_ren  = 1'b1;
        #1;
        data     = bus_rdata;
        bus_ren  = 1'b0;
    endtask

    task automatic read_ram(input logic [31:0] addr, output logic [31:0] data);
        bus_addr = addr;
        bus_ren  = 1'b1;
        step();
        data     = bus_rdata;
        bus_ren  = 1'b0;
    endtask

    task automatic pulse_trigger();
        trigger_in = 1'b1;
        step();
        trigger_in = 1'b0;
    endtask

    // Called in the PRIME cycle (T+1); checks exp_seq words at T+2.. and
    // the DONE cycle that follows.
    task automatic expect_play(input string tag);
        logic [31:0] r;
        read_reg(R_STIM_STATUS, r);
        check({tag, " prime status"}, r, 32'h2);
        check({tag, " prime valid"}, 32'(pattern_valid), 32'h0);
        foreach (exp_seq[k]) begin
            step();
            check($sformatf("%s valid[%0d]", tag, k), 32'(pattern_valid), 32'h1);
            check($sformatf("%s word[%0d]", tag, k), 32'(pattern_out), exp_seq[k]);
        end
        step();
        check({tag, " done valid"}, 32'(pattern_valid), 32'h0);
        check({tag, " done out"}, 32'(pattern_out), 32'h0);
        check({tag, " done busy"}, 32'(busy), 32'h0);
        read_reg(R_STIM_STATUS, r);
        check({tag, " done status"}, r, 32'h4);
    endtask

    initial begin
        logic [31:0] r;
        int          vcount;
        int          nloop;

        rst = 1'b1; trigger_in = 1'b0;
        bus_addr = R_STIM_STATUS; bus_wen = 1'b0; bus_ren = 1'b0; bus_wdata = '0;
        repeat (3) step();
        rst = 1'b0;

        // Reset state
        check("rst valid", 32'(pattern_valid), 32'h0);
        check("rst out", 32'(pattern_out), 32'h0);
        check("rst busy", 32'(busy), 32'h0);

        // Trigger in IDLE is ignored
        pulse_trigger();
        step();
        check("idle trig busy", 32'(busy), 32'h0);
        check("idle trig valid", 32'(pattern_valid), 32'h0);

        // Register / RAM access table
        add_vec("info",        0, 0, R_STIM_INFO,   32'h0,          32'h0010_000C);
        add_vec("status rst",  0, 0, R_STIM_STATUS, 32'h0,          32'h0);
        add_vec("len rst",     0, 0, R_STIM_LEN,    32'h0,          32'h0);
        add_vec("loops rst",   0, 0, R_STIM_LOOPS,  32'h0,          32'h0);
        add_vec("len 4",       1, 0, R_STIM_LEN,    32'd4,          32'd4);
        add_vec("len 100",     1, 0, R_STIM_LEN,    32'd100,        32'd16);
        add_vec("len 16",      1, 0, R_STIM_LEN,    32'd16,         32'd16);
        add_vec("len 17",      1, 0, R_STIM_LEN,    32'd17,         32'd16);
        add_vec("len 15",      1, 0, R_STIM_LEN,    32'd15,         32'd15);
        add_vec("loops 5",     1, 0, R_STIM_LOOPS,  32'd5,          LOOP_EN ? 32'd5 : 32'd0);
        add_vec("loops 0",     1, 0, R_STIM_LOOPS,  32'd0,          32'd0);
        add_vec("ctrl rd",     1, 0, R_STIM_CTRL,   32'h0,          32'h0);
        add_vec("ram 3",       1, 1, 32'd3,         32'h0000_0ABC,  32'h0000_0ABC);
        add_vec("ram 5 trunc", 1, 1, 32'd5,         32'hFFFF_F123,  32'h0000_0123);
        add_vec("ram 3 again", 0, 1, 32'd3,         32'h0,          32'h0000_0ABC);

        foreach (vecs[i]) begin
            if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].wdata);
            if (vecs[i].ram) read_ram(vecs[i].addr, r);
            else             read_reg(vecs[i].addr, r);
            check(vecs[i].name, r, vecs[i].exp);
        end

        // Basic playback
        bus_write(32'd0, 32'h11); bus_write(32'd1, 32'h22);
        bus_write(32'd2, 32'h33); bus_write(32'd3, 32'h44);
        bus_write(R_STIM_LEN, 32'd4);
        bus_write(R_STIM_CTRL, 32'h1);
        read_reg(R_STIM_STATUS, r);
        check("armed status", r, 32'h1);
        check("armed busy", 32'(busy), 32'h1);
        exp_seq = '{32'h11, 32'h22, 32'h33, 32'h44};
        pulse_trigger();
        expect_play("basic");

        // Triggers during PLAY and DONE are ignored
        bus_write(R_STIM_CTRL, 32'h1);
        bus_addr = R_STIM_STATUS;
        trigger_in = 1'b1;
        vcount = 0;
        for (int i = 0; i < 14; i++) begin
            step();
            trigger_in = (i == 2 || i == 3 || i == 10);
            if (pattern_valid) vcount++;
        end
        trigger_in = 1'b0;
        check("retrig valid count", 32'(vcount), 32'd4);
        read_reg(R_STIM_STATUS, r);
        check("retrig status", r, 32'h4);

        // Software trigger, then ABORT in the second PLAY cycle
        bus_write(R_STIM_CTRL, 32'h1);
        bus_write(R_STIM_CTRL, 32'h4);
        step();
        check("abort p0 word", 32'(pattern_out), 32'h11);
        step();
        check("abort p1 valid", 32'(pattern_valid), 32'h1);
        check("abort p1 word", 32'(pattern_out), 32'h22);
        bus_write(R_STIM_CTRL, 32'h2);
        check("abort valid", 32'(pattern_valid), 32'h0);
        check("abort out", 32'(pattern_out), 32'h0);
        check("abort busy", 32'(busy), 32'h0);
        read_reg(R_STIM_STATUS, r);
        check("abort status", r, 32'h0);

        // ARM and ABORT together: ABORT wins
        bus_write(R_STIM_CTRL, 32'h3);
        check("arm+abort busy", 32'(busy), 32'h0);
        read_reg(R_STIM_STATUS, r);
        check("arm+abort status", r, 32'h0);

        // Zero length ARM is ignored
        bus_write(R_STIM_LEN, 32'd0);
        bus_write(R_STIM_CTRL, 32'h1);
        check("len0 busy", 32'(busy), 32'h0);
        pulse_trigger();
        step();
        check("len0 valid", 32'(pattern_valid), 32'h0);
        read_reg(R_STIM_STATUS, r);
        check("len0 status", r, 32'h0);

        // Full depth with clamped length
        for (int i = 0; i < D; i++) begin
            exp_mem[i] = 12'(i * 257 + 7);
            bus_write(32'(i), 32'(exp_mem[i]));
        end
        bus_write(R_STIM_LEN, 32'(D + 5));
        read_reg(R_STIM_LEN, r);
        check("len clamp", r, 32'(D));
        exp_seq.delete();
        for (int i = 0; i < D; i++) exp_seq.push_back(32'(exp_mem[i]));
        bus_write(R_STIM_CTRL, 32'h1);
        pulse_trigger();
        expect_play("full");

        // Reset during PLAY
        bus_write(R_STIM_CTRL, 32'h1);
        pulse_trigger();
        repeat (3) step();
        check("pre-rst valid", 32'(pattern_valid), 32'h1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst valid", 32'(pattern_valid), 32'h0);
        check("midrst out", 32'(pattern_out), 32'h0);
        check("midrst busy", 32'(busy), 32'h0);
        read_reg(R_STIM_STATUS, r);
        check("midrst status", r, 32'h0);
        read_reg(R_STIM_LEN, r);
        check("midrst len", r, 32'h0);
        bus_write(R_STIM_LEN, 32'd4);
        bus_write(R_STIM_CTRL, 32'h1);
        exp_seq.delete();
        for (int i = 0; i < 4; i++) exp_seq.push_back(32'(exp_mem[i]));
        pulse_trigger();
        expect_play("post-rst");

        // Looping
        bus_write(32'd0, 32'h0A0A); bus_write(32'd1, 32'h0B0B); bus_write(32'd2, 32'h0C0C);
        bus_write(R_STIM_LEN, 32'd3);
        bus_write(R_STIM_LOOPS, 32'd2);
        nloop = LOOP_EN ? 3 : 1;
        exp_seq.delete();
        for (int p = 0; p < nloop; p++) begin
            exp_seq.push_back(32'h0A0A);
            exp_seq.push_back(32'h0B0B);
            exp_seq.push_back(32'h0C0C);
        end
        bus_write(R_STIM_CTRL, 32'h1);
        pulse_trigger();
        expect_play("loop");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
